// File: rtl/zports_pkg.sv
// zports_pkg: shared port addresses, SPI engine states and CFG bit positions
package zports_pkg;
    localparam logic [7:0] CFG_PORT_DEF = 8'h77;
    localparam logic [7:0] DAT_PORT_DEF = 8'h57;
    localparam logic [7:0] DIV_PORT_DEF = 8'hB7;
    localparam int         CFG_BUSY_BIT = 7;
    typedef enum logic {SPI_IDLE, SPI_SHIFT} spi_state_e;
endpackage

// File: rtl/zspi_shifter.sv
// zspi_shifter: mode-0 SPI byte engine with programmable SCK half-period
module zspi_shifter
    import zports_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx,
    input  logic [7:0] div,
    input  logic       miso,
    output logic       busy,
    output logic [7:0] rx,
    output logic       sck,
    output logic       mosi
);
    spi_state_e state_q;
    logic [7:0] cnt_q, div_q, sh_q, rx_q;
    logic [3:0] edges_q;
    logic       cap_q, busy_q, sck_q, mosi_q;
    assign busy = busy_q;
    assign rx   = rx_q;
    assign sck  = sck_q;
    assign mosi = mosi_q;
    // engine FSM: sample MISO on rising SCK, shift on falling SCK, finish on the 16th edge
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= SPI_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            sh_q    <= '0;
            rx_q    <= 8'hFF;
            edges_q <= '0;
            cap_q   <= 1'b1;
            busy_q  <= 1'b0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b1;
        end else if (state_q == SPI_IDLE) begin
            if (start) begin
                state_q <= SPI_SHIFT;
                busy_q  <= 1'b1;
                sh_q    <= tx;
                mosi_q  <= tx[7];
                cnt_q   <= '0;
                edges_q <= '0;
                div_q   <= div;
            end
        end else if (cnt_q != div_q) begin
            cnt_q <= cnt_q + 8'd1;
        end else begin
            cnt_q   <= '0;
            sck_q   <= ~sck_q;
            edges_q <= edges_q + 4'd1;
            if (!sck_q)
                cap_q <= miso;
            else if (edges_q == 4'd15) begin
                rx_q    <= {sh_q[6:0], cap_q};
                busy_q  <= 1'b0;
                mosi_q  <= 1'b1;
                state_q <= SPI_IDLE;
            end else begin
                sh_q   <= {sh_q[6:0], cap_q};
                mosi_q <= sh_q[6];
            end
        end
endmodule

// File: rtl/zspi_ports.sv
// zspi_ports: Z80 I/O-mapped SPI master with CFG/DAT/DIV ports and WAIT hold-off
module zspi_ports
    import zports_pkg::*;
#(
    parameter logic [7:0] CFG_PORT = CFG_PORT_DEF,
    parameter logic [7:0] DAT_PORT = DAT_PORT_DEF,
    parameter logic [7:0] DIV_PORT = DIV_PORT_DEF,
    parameter int         NCS      = 2,
    parameter logic [7:0] DIV_RST  = 8'd1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [7:0]     a,
    input  logic [7:0]     din,
    input  logic           iorq_n,
    input  logic           rd_n,
    input  logic           wr_n,
    output logic [7:0]     dout,
    output logic           dataout,
    output logic           porthit,
    output logic           wait_n,
    output logic           busy,
    output logic [NCS-1:0] spi_cs_n,
    output logic           spi_sck,
    output logic           spi_mosi,
    input  logic           spi_miso
);
    logic           hit_cfg, hit_dat, hit_div, acc, strobe, start;
    logic           acc_seen_q, acc_seen_d;
    logic [NCS-1:0] cs_q, cs_d;
    logic [7:0]     div_q, div_d, rx, cfg_rd;
    assign hit_cfg  = a == CFG_PORT;
    assign hit_dat  = a == DAT_PORT;
    assign hit_div  = a == DIV_PORT;
    assign porthit  = hit_cfg | hit_dat | hit_div;
    assign acc      = ~iorq_n & (~rd_n | ~wr_n) & porthit;
    assign strobe   = acc & ~acc_seen_q & ~(busy & hit_dat);
    assign start    = strobe & hit_dat;
    assign wait_n   = ~(acc & hit_dat & busy);
    assign dataout  = porthit & ~iorq_n & ~rd_n;
    assign spi_cs_n = cs_q;
    // next-state for the one-strobe-per-cycle latch and the CFG/DIV registers
    always_comb begin
        acc_seen_d = iorq_n ? 1'b0 : (acc_seen_q | strobe);
        cs_d       = (strobe & hit_cfg & ~wr_n) ? din[NCS-1:0] : cs_q;
        div_d      = (strobe & hit_div & ~wr_n) ? din : div_q;
    end
    // status byte: busy on top, chip selects in the low bits
    always_comb begin
        cfg_rd               = '0;
        cfg_rd[CFG_BUSY_BIT] = busy;
        cfg_rd[NCS-1:0]      = cs_q;
    end
    // CPU read mux, combinational from the address
    always_comb dout = hit_cfg ? cfg_rd : hit_dat ? rx : hit_div ? div_q : 8'hFF;
    // port registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            acc_seen_q <= 1'b0;
            cs_q       <= '1;
            div_q      <= DIV_RST;
        end else begin
            acc_seen_q <= acc_seen_d;
            cs_q       <= cs_d;
            div_q      <= div_d;
        end
    zspi_shifter u_shifter (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .tx    (~wr_n ? din : 8'hFF),
        .div   (div_q),
        .miso  (spi_miso),
        .busy  (busy),
        .rx    (rx),
        .sck   (spi_sck),
        .mosi  (spi_mosi)
    );
endmodule

// File: tb/tb_zspi_ports.sv
// tb_zspi_ports: directed Z80 IO cycles against zspi_ports with a model SPI slave
module tb_zspi_ports;
    localparam logic [7:0] CFG = 8'h77, DAT = 8'h57, DIV = 8'hB7;
    logic       clk = 0, rst_n = 0, iorq_n = 1, rd_n = 1, wr_n = 1, spi_miso;
    logic [7:0] a = 8'h00, din = 8'h00, dout;
    logic       dataout, porthit, wait_n, busy, spi_sck, spi_mosi;
    logic [1:0] spi_cs_n;
    logic [7:0] slv_byte = 8'hFF, mosi_cap = 8'h00, r;
    int         nrise = 0, nfall = 0, fall_base = 0, nxfer = 0, idx, w, bc, x0, eb;
    time        t_prev = 0, t_last = 0;
    int         total = 0, bad = 0;
    logic       dataout_s;

    zspi_ports dut (
        .clk(clk), .rst_n(rst_n), .a(a), .din(din), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .dout(dout), .dataout(dataout), .porthit(porthit), .wait_n(wait_n), .busy(busy),
        .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    always @(posedge spi_sck) begin
        mosi_cap = {mosi_cap[6:0], spi_mosi};
        t_prev = t_last;
        t_last = $time;
        nrise++;
    end
    always @(negedge spi_sck) nfall++;
    always @(posedge busy) begin
        fall_base = nfall;
        nxfer++;
    end
    always_comb begin
        idx = nfall - fall_base;
        spi_miso = (idx < 8) ? slv_byte[3'd7 - idx[2:0]] : 1'b1;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic io(input logic [7:0] addr, input logic wr, input logic [7:0] data,
                      output logic [7:0] rd_data, output int waits);
        @(negedge clk);
        a = addr; din = data; iorq_n = 0; wr_n = ~wr; rd_n = wr;
        waits = 0;
        #1;
        while (!wait_n && waits < 2000) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (waits >= 2000) check("wait_timeout", waits, 0);
        rd_data = dout;
        dataout_s = dataout;
        @(negedge clk);
        iorq_n = 1; rd_n = 1; wr_n = 1; a = 8'h00;
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (busy && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle;
        int n = 0;
        while (busy && n < 5000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 5000) check("idle_timeout", n, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_cs", spi_cs_n, 2'b11);
        check("rst_sck", spi_sck, 0);
        check("rst_mosi", spi_mosi, 1);
        check("rst_busy", busy, 0);
        check("rst_wait", wait_n, 1);
        rst_n = 1;
        @(negedge clk);
        check("nohit_porthit", porthit, 0);
        check("nohit_dout", dout, 8'hFF);

        io(CFG, 0, 0, r, w);  check("in_cfg", r, 8'h03);  check("dataout", dataout_s, 1);
        io(DIV, 0, 0, r, w);  check("in_div", r, 8'h01);

        io(CFG, 1, 8'h02, r, w);  check("cs_sel", spi_cs_n, 2'b10);
        slv_byte = 8'h3C;
        io(DAT, 1, 8'hA5, r, w);
        busy_len(bc);               check("busy_div1", bc, 32);
        check("mosi_a5", mosi_cap, 8'hA5);
        check("half_div1", int'(t_last - t_prev), 40);
        check("idle_mosi", spi_mosi, 1);

        io(DIV, 1, 8'h04, r, w);
        slv_byte = 8'h96;
        io(DAT, 0, 0, r, w);        check("in_dat_3c", r, 8'h3C);
        busy_len(bc);               check("busy_div4", bc, 80);
        check("mosi_ff", mosi_cap, 8'hFF);
        check("half_div4", int'(t_last - t_prev), 100);

        x0 = nxfer;
        slv_byte = 8'h5A;
        io(DAT, 1, 8'h11, r, w);
        io(DAT, 1, 8'h22, r, w);    check("b2b_waits", w, 79);
        io(DIV, 1, 8'h01, r, w);
        wait_idle();
        check("b2b_xfers", nxfer - x0, 2);
        check("mosi_22", mosi_cap, 8'h22);
        check("half_old_div", int'(t_last - t_prev), 100);

        io(DAT, 0, 0, r, w);        check("in_dat_5a", r, 8'h5A);
        busy_len(bc);               check("busy_new_div", bc, 32);
        check("half_new_div", int'(t_last - t_prev), 40);

        io(CFG, 0, 0, r, w);        check("cfg_idle", r, 8'h02);
        io(DAT, 1, 8'h33, r, w);
        io(CFG, 0, 0, r, w);        check("cfg_busy", r, 8'h82);
        wait_idle();
        eb = nrise + nfall;
        io(DAT, 1, 8'h33, r, w);
        for (int i = 0; i < 200 && (nrise + nfall - eb) < 7; i++) begin
            @(posedge clk);
            #1;
        end
        check("edge7_reached", nrise + nfall - eb, 7);
        rst_n = 0;
        #1;
        check("abort_sck", spi_sck, 0);
        check("abort_busy", busy, 0);
        check("abort_cs", spi_cs_n, 2'b11);
        @(negedge clk);
        rst_n = 1;
        io(DAT, 0, 0, r, w);        check("abort_rx", r, 8'hFF);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
